// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source and load-size codes
// plus the FSM state type.
package wb_pkg;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;
  localparam logic [1:0] WB_SRC_IMM = 2'd3;

  localparam logic [1:0] WB_LS_B = 2'd0;
  localparam logic [1:0] WB_LS_H = 2'd1;
  localparam logic [1:0] WB_LS_W = 2'd2;
  localparam logic [1:0] WB_LS_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load aligner/extender: shifts the addressed lane down to bit 0
// and sign- or zero-extends byte/half/word loads to XLEN.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] addr_lo,
  input  logic [1:0]       load_size,
  input  logic             load_unsigned,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ext_w;

  assign lane = rdata >> {addr_lo, 3'b000};

  // A word load only needs extension when the datapath is wider than 32 bits.
  generate
    if (XLEN > 32) begin : g_wide
      assign ext_w = {{(XLEN-32){~load_unsigned & lane[31]}}, lane[31:0]};
    end else begin : g_narrow
      assign ext_w = lane;
    end
  endgenerate

  always_comb begin
    data = lane;
    case (load_size)
      WB_LS_B: data = {{(XLEN-8){~load_unsigned & lane[7]}}, lane[7:0]};
      WB_LS_H: data = {{(XLEN-16){~load_unsigned & lane[15]}}, lane[15:0]};
      WB_LS_W: data = ext_w;
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RISC-V writeback stage: result select, late-load wait FSM and registered
// register-file write port. Define WB_LOAD_EXT_EN to enable sub-word load align/extend.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [1:0]       result_src,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  imm,
  input  logic [RA_W-1:0]  rd,
  input  logic             reg_write,
  input  logic [1:0]       load_size,
  input  logic             load_unsigned,
  input  logic [OFF_W-1:0] addr_lo,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [XLEN-1:0]  result_w,
  output logic [RA_W-1:0]  rd_w,
  output logic             reg_write_w,
  output logic             busy
);

  // Handshake: an instruction transfers on a rising edge where in_valid &
  // in_ready; flush in the same cycle cancels it. in_ready is high only in IDLE.

  wb_state_t       state, next_state;
  logic [RA_W-1:0] p_rd;
  logic            p_we;
  logic            latch;
  logic            commit;
  logic [XLEN-1:0] c_result;
  logic [RA_W-1:0] c_rd;
  logic            c_we;
  logic [XLEN-1:0] mem_data;

`ifdef WB_LOAD_EXT_EN
  logic [1:0]       p_ls;
  logic             p_uns;
  logic [OFF_W-1:0] p_off;

  // While waiting, the extender must use the attributes captured at accept.
  load_extend #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_extend (
    .rdata         (mem_rdata),
    .addr_lo       ((state == IDLE) ? addr_lo       : p_off),
    .load_size     ((state == IDLE) ? load_size     : p_ls),
    .load_unsigned ((state == IDLE) ? load_unsigned : p_uns),
    .data          (mem_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_ls  <= WB_LS_B;
      p_uns <= 1'b0;
      p_off <= '0;
    end else if (latch) begin
      p_ls  <= load_size;
      p_uns <= load_unsigned;
      p_off <= addr_lo;
    end
  end
`else
  logic unused_ext;
  assign unused_ext = ^{load_size, load_unsigned, addr_lo};
  assign mem_data   = mem_rdata;
`endif

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    latch      = 1'b0;
    commit     = 1'b0;
    c_result   = mem_data;
    c_rd       = p_rd;
    c_we       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          if (result_src != WB_SRC_MEM || mem_rvalid) begin
            commit = 1'b1;
            c_rd   = rd;
            c_we   = reg_write;
            case (result_src)
              WB_SRC_ALU: c_result = alu_result;
              WB_SRC_PC4: c_result = pc_plus4;
              WB_SRC_IMM: c_result = imm;
              default:    c_result = mem_data;
            endcase
          end else begin
            latch      = 1'b1;
            next_state = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          next_state = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          commit     = 1'b1;
          c_we       = p_we;
          next_state = IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      p_rd        <= '0;
      p_we        <= 1'b0;
      result_w    <= '0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      state       <= next_state;
      reg_write_w <= commit && c_we && (c_rd != '0);
      if (latch) begin
        p_rd <= rd;
        p_we <= reg_write;
      end
      if (commit) begin
        result_w <= c_result;
        rd_w     <= c_rd;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a driver pushes expected register-file
// writes into a queue and a negedge monitor pops them as reg_write_w strobes.
module tb_writeback_stage;
  import wb_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int OFF_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [1:0]       result_src;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  imm;
  logic [RA_W-1:0]  rd;
  logic             reg_write;
  logic [1:0]       load_size;
  logic             load_unsigned;
  logic [OFF_W-1:0] addr_lo;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic [XLEN-1:0]  result_w;
  logic [RA_W-1:0]  rd_w;
  logic             reg_write_w;
  logic             busy;

  int tests  = 0;
  int errors = 0;
  logic [RA_W+XLEN-1:0] exp_q[$];

  writeback_stage #(.XLEN(XLEN), .RA_W(RA_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .result_src(result_src), .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
    .rd(rd), .reg_write(reg_write), .load_size(load_size), .load_unsigned(load_unsigned),
    .addr_lo(addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ld_exp(input logic [XLEN-1:0] ext_val,
                                             input logic [XLEN-1:0] raw);
`ifdef WB_LOAD_EXT_EN
    ld_exp = ext_val;
`else
    ld_exp = raw;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] src, input logic [XLEN-1:0] val,
                       input logic [RA_W-1:0] r, input logic we,
                       input logic [1:0] ls, input logic uns, input logic [OFF_W-1:0] off,
                       input logic rv, input logic fl);
    in_valid      = 1'b1;
    result_src    = src;
    alu_result    = (src == WB_SRC_ALU) ? val : 32'h0BAD_0A11;
    pc_plus4      = (src == WB_SRC_PC4) ? val : 32'h0BAD_0C04;
    imm           = (src == WB_SRC_IMM) ? val : 32'h0BAD_01AA;
    mem_rdata     = (src == WB_SRC_MEM) ? val : 32'h0BAD_0DA7;
    rd            = r;
    reg_write     = we;
    load_size     = ls;
    load_unsigned = uns;
    addr_lo       = off;
    mem_rvalid    = rv;
    flush         = fl;
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && reg_write_w) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h, required no write", rd_w, result_w);
      end else begin
        logic [RA_W+XLEN-1:0] e;
        e = exp_q.pop_front();
        if ({rd_w, result_w} !== e) begin
          errors++;
          $display("FAIL wb_write: got rd=%0d data=0x%0h, required rd=%0d data=0x%0h",
                   rd_w, result_w, e[RA_W+XLEN-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; result_src = WB_SRC_ALU;
    alu_result = '0; pc_plus4 = '0; imm = '0; rd = '0; reg_write = 1'b0;
    load_size = WB_LS_W; load_unsigned = 1'b0; addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("rst_result_w", result_w, 0);
    check("rst_rd_w", rd_w, 0);
    check("rst_reg_write_w", reg_write_w, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);

    // ALU op, latency 1
    exp_q.push_back({5'd5, 32'h0000_1234});
    issue(WB_SRC_ALU, 32'h0000_1234, 5'd5, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    check("alu_result_w", result_w, 32'h0000_1234);
    check("alu_rd_w", rd_w, 5);

    // Sub-word loads with data valid in the accept cycle
    exp_q.push_back({5'd6, ld_exp(32'hFFFF_FF80, 32'h80FF_7F01)});
    issue(WB_SRC_MEM, 32'h80FF_7F01, 5'd6, 1'b1, WB_LS_B, 1'b0, 2'd3, 1'b1, 1'b0);
    exp_q.push_back({5'd7, ld_exp(32'h0000_0080, 32'h80FF_7F01)});
    issue(WB_SRC_MEM, 32'h80FF_7F01, 5'd7, 1'b1, WB_LS_B, 1'b1, 2'd3, 1'b1, 1'b0);
    exp_q.push_back({5'd8, ld_exp(32'hFFFF_80FF, 32'h80FF_7F01)});
    issue(WB_SRC_MEM, 32'h80FF_7F01, 5'd8, 1'b1, WB_LS_H, 1'b0, 2'd2, 1'b1, 1'b0);
    exp_q.push_back({5'd9, ld_exp(32'h0000_007F, 32'h80FF_7F01)});
    issue(WB_SRC_MEM, 32'h80FF_7F01, 5'd9, 1'b1, WB_LS_B, 1'b1, 2'd1, 1'b1, 1'b0);
    exp_q.push_back({5'd10, ld_exp(32'h0000_7F01, 32'h80FF_7F01)});
    issue(WB_SRC_MEM, 32'h80FF_7F01, 5'd10, 1'b1, WB_LS_H, 1'b0, 2'd0, 1'b1, 1'b0);

    // Late LW: three cycles of stall, then data
    issue(WB_SRC_MEM, 32'h0, 5'd11, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("late_in_ready", in_ready, 0);
      check("late_busy", busy, 1);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    exp_q.push_back({5'd11, 32'hDEAD_BEEF});
    tick();
    mem_rvalid = 1'b0;
    check("late_ready_after", in_ready, 1);
    check("late_result_w", result_w, 32'hDEAD_BEEF);

    // Flush while waiting: DRAIN until the orphan response, no write
    issue(WB_SRC_MEM, 32'h0, 5'd12, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state_drain", dut.state, DRAIN);
    tick();
    tick();
    check("drain_in_ready", in_ready, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    check("drain_exit_idle", busy, 0);
    check("drain_result_hold", result_w, 32'hDEAD_BEEF);

    // Flush and response together in WAIT_MEM: consumed, no write
    issue(WB_SRC_MEM, 32'h0, 5'd13, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    mem_rvalid = 1'b1; flush = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0; flush = 1'b0;
    check("flush_rvalid_idle", busy, 0);

    // rd=0 commits the value but never strobes the write
    issue(WB_SRC_PC4, 32'h0000_0104, 5'd0, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    check("rd0_result_w", result_w, 32'h0000_0104);
    check("rd0_rd_w", rd_w, 0);

    // Flush in IDLE drops the incoming instruction
    issue(WB_SRC_ALU, 32'h7777_7777, 5'd14, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b1);
    check("idle_flush_hold", result_w, 32'h0000_0104);

    // LUI-style immediate
    exp_q.push_back({5'd15, 32'h1234_5000});
    issue(WB_SRC_IMM, 32'h1234_5000, 5'd15, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in WAIT_MEM
    issue(WB_SRC_MEM, 32'h0, 5'd16, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_result_w", result_w, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back({5'd17, 32'h0000_0ABC});
    issue(WB_SRC_ALU, 32'h0000_0ABC, 5'd17, 1'b1, WB_LS_W, 1'b0, 2'd0, 1'b0, 1'b0);
    check("post_rst_result_w", result_w, 32'h0000_0ABC);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
